// File: rtl/guess_input.sv
// guess_input: synchronise and debounce active-low tile buttons, emit one one-hot guess per press
module guess_input #(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  output logic [NUM_BUTTONS-1:0] guess,
  output logic                   guess_valid,
  output logic                   held
);
  typedef enum logic [1:0] {IDLE, EMIT, LOCK} state_t;
  state_t state, state_next;
  logic [NUM_BUTTONS-1:0] s1, s2, sync, stable, guess_next;
  logic [CNT_W-1:0] cnt [NUM_BUTTONS];
  logic any;
  assign sync = ~s2;
  assign any = |stable;
  assign guess_valid = state == EMIT;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end
  // a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++)
        if (sync[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      guess <= '0;
      held <= 1'b0;
    end else begin
      state <= state_next;
      guess <= guess_next;
      held <= any;
    end
  end
  // isolating the lowest set bit gives lowest-index priority for simultaneous presses
  always_comb begin
    state_next = state == EMIT ? LOCK :
                 state == LOCK ? (any ? LOCK : IDLE) :
                 any ? (enable ? EMIT : LOCK) : IDLE;
    guess_next = (state == IDLE && any && enable) ? stable & (~stable + NUM_BUTTONS'(1)) : guess;
  end
endmodule

// File: tb/tb_guess_input.sv
// tb_guess_input: directed test-plan scenarios plus random presses against a sample-history model
module tb_guess_input;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b1;
  logic [7:0] btn_n = 8'hFF;
  logic [7:0] guess;
  logic guess_valid, held;
  int n_chk = 0, n_fail = 0, strobes = 0;
  logic [15:0] hist [8];
  logic [7:0] st_m = '0, g_m = '0;
  logic v_m = 1'b0, h_m = 1'b0, lk = 1'b0;

  guess_input #(.NUM_BUTTONS(8), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .btn_n(btn_n),
    .guess(guess), .guess_valid(guess_valid), .held(held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // a button level counts as settled once D consecutive synchronised samples agree
  task automatic model_edge();
    logic any, nv, nl;
    logic [7:0] ng;
    if (!reset) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      st_m = '0; g_m = '0; v_m = 0; h_m = 0; lk = 0;
      return;
    end
    any = |st_m;
    ng = g_m; nv = 0; nl = lk;
    if (v_m) nl = 1;
    else if (lk) nl = any;
    else if (any) begin
      if (enable) begin
        nv = 1;
        for (int i = 7; i >= 0; i--) if (st_m[i]) ng = 8'(1 << i);
      end else nl = 1;
    end
    h_m = any;
    for (int i = 0; i < 8; i++) begin
      if (&hist[i][D:1]) st_m[i] = 1'b1;
      else if (~|hist[i][D:1]) st_m[i] = 1'b0;
      hist[i] = {hist[i][14:0], ~btn_n[i]};
    end
    g_m = ng; v_m = nv; lk = nl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("guess", guess, g_m);
    check("guess_valid", 8'(guess_valid), 8'(v_m));
    check("held", 8'(held), 8'(h_m));
    if (guess_valid) strobes++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    // 1: reset then idle
    run(2);
    reset = 1;
    run(20);
    check("t1_strobes", 8'(strobes), 8'd0);
    check("t1_guess", guess, 8'h00);
    check("t1_held", 8'(held), 8'd0);
    // 2: single press, exact latency
    strobes = 0;
    btn_n = 8'hF7;
    run(6);
    check("t2_early", 8'(guess_valid), 8'd0);
    check("t2_early_held", 8'(held), 8'd0);
    run(1);
    check("t2_valid", 8'(guess_valid), 8'd1);
    check("t2_guess", guess, 8'h08);
    check("t2_held", 8'(held), 8'd1);
    run(13);
    btn_n = 8'hFF;
    run(6);
    check("t2_held_rel", 8'(held), 8'd1);
    run(1);
    check("t2_held_off", 8'(held), 8'd0);
    check("t2_strobes", 8'(strobes), 8'd1);
    // 3: short glitches never accepted
    strobes = 0;
    repeat (5) begin
      btn_n = 8'hDF; run(3);
      btn_n = 8'hFF; run(1);
    end
    run(8);
    check("t3_strobes", 8'(strobes), 8'd0);
    check("t3_guess", guess, 8'h08);
    // 4: simultaneous presses, lockout
    strobes = 0;
    btn_n = 8'hBD; run(8);
    check("t4_guess", guess, 8'h02);
    btn_n = 8'hBF; run(10);
    check("t4_lock", 8'(strobes), 8'd1);
    btn_n = 8'hFF; run(8);
    btn_n = 8'hBF; run(8);
    check("t4_guess2", guess, 8'h40);
    check("t4_strobes", 8'(strobes), 8'd2);
    btn_n = 8'hFF; run(8);
    // 5: disabled press discarded
    strobes = 0;
    enable = 0;
    btn_n = 8'hFE; run(8);
    btn_n = 8'hFF; run(8);
    check("t5_dis", 8'(strobes), 8'd0);
    check("t5_guess", guess, 8'h40);
    enable = 1;
    btn_n = 8'hFE; run(8);
    check("t5_guess2", guess, 8'h01);
    check("t5_strobes", 8'(strobes), 8'd1);
    btn_n = 8'hFF; run(8);
    // 6: reset mid-debounce, button held through
    strobes = 0;
    btn_n = 8'hFB; run(2);
    reset = 0; run(1);
    check("t6_guess", guess, 8'h00);
    check("t6_held", 8'(held), 8'd0);
    reset = 1;
    run(6);
    check("t6_early", 8'(guess_valid), 8'd0);
    run(1);
    check("t6_valid", 8'(guess_valid), 8'd1);
    check("t6_guess2", guess, 8'h04);
    btn_n = 8'hFF; run(8);
    // random traffic, checked every cycle against the model
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom % 4) != 0;
      case ($urandom % 4)
        0, 1: btn_n = 8'hFF;
        2: btn_n = ~8'(1 << ($urandom % 8));
        default: btn_n = 8'($urandom);
      endcase
      reset = ($urandom % 40) != 0;
      run(1);
      reset = 1;
      run($urandom_range(0, 8));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/guess_input.md
Name: guess_input

Overview:
- Produces player guesses for the Memory Matrix tile grid from raw GPIO push-buttons.
- Synchronises and debounces eight active-low buttons, then encodes a single accepted press as a one-hot guess plus a one-cycle strobe.
- Sits between the board GPIO pins and the game controller/datapath. guess drives the datapath guess input; guess_valid is the controller's board_moved event.
- Enforces one guess per physical press, with a release lockout.

Parameters:
NUM_BUTTONS, 8, number of tile buttons; also the width of guess.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz). Benches use 4.
CNT_W, 19, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-low reset
enable  input  1  1 = guesses accepted (controller in play state); 0 = presses discarded
btn_n  input  NUM_BUTTONS  raw asynchronous buttons; 0 = pressed
guess  output  NUM_BUTTONS  one-hot code of the last accepted press; registered
guess_valid  output  1  one-cycle strobe when guess is updated
held  output  1  1 while any debounced button is pressed

Behaviour:
- Reset is sampled on posedge clk while reset==0. Reset applies to every register:
  - synchroniser flops = all 1 (released);
  - debounced state = all released;
  - debounce counters = 0;
  - FSM = IDLE;
  - guess = 0, guess_valid = 0, held = 0.
  - Reset mid-debounce or mid-lockout discards the in-flight press.
- Synchroniser: 2-flop chain per button. sync = ~second flop (1 = pressed).
- Debounce, per button i:
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count. Counters never wrap.
- held = |stable, registered.
- FSM states and transitions:
  - IDLE: if |stable == 1:
    - if enable == 1, go to EMIT and load guess with the lowest-index set bit of stable (one-hot);
    - if enable == 0, go to LOCK and leave guess unchanged (press discarded).
  - EMIT: guess_valid = 1 for exactly this one cycle; unconditionally go to LOCK.
  - LOCK: stay until stable == 0 (all buttons released), then go to IDLE. No strobe is generated in LOCK, so extra buttons pressed while one is held are ignored.
- Latency: let edge k be the first edge sampling a new constant level on btn_n[i].
  - stable[i] flips at edge k+1+DEBOUNCE_CYCLES.
  - The FSM enters EMIT at edge k+2+DEBOUNCE_CYCLES.
  - guess_valid is high for the single cycle following that edge.
  - guess is valid from the same edge and holds until the next EMIT or reset.
- Simultaneous events:
  - Multiple buttons that stabilise on the same edge: lowest index wins, one strobe only.
  - enable falling during EMIT: the strobe still completes.
  - enable is sampled only in IDLE.
- A button held through reset release debounces as a fresh press and yields one guess if enable == 1.
- guess is always either 0 (after reset) or exactly one-hot.

Test Plan (DEBOUNCE_CYCLES=4):
1. reset=0 for 2 cycles, then btn_n=8'hFF with enable=1 -> guess=0, guess_valid=0 and held=0 for 20 cycles.
2. enable=1; btn_n[3] driven 0 at edge k and held; released after 20 cycles -> guess_valid high only in the cycle after edge k+6; guess=8'h08 from then on; held=1 from edge k+6 until 6 cycles after release; exactly one strobe.
3. btn_n[5] pulses low for 3 cycles, repeated 5 times with 1-cycle gaps -> no strobe, guess unchanged, held=0.
4. btn_n[6] and btn_n[1] go low on the same edge (enable=1) -> single strobe, guess=8'h02. Releasing btn_n[1] while btn_n[6] is still held -> no further strobe until both are released and btn_n[6] is pressed again, which then gives guess=8'h40.
5. enable=0; press and release btn_n[0] -> no strobe, guess keeps its prior value. Then enable=1; press btn_n[0] again -> strobe, guess=8'h01.
6. Assert reset 2 cycles into the debounce of btn_n[2], with the button still held -> all outputs 0. After reset deasserts, the press is accepted DEBOUNCE_CYCLES+2 edges later with guess=8'h04.
